// File: rtl/fact_ctrl.sv
// fact_ctrl: Moore controller for an iterative factorial datapath.
// It sequences an external counter/product register pair so that the product
// register ends up holding n! for 0 <= n <= MAX_N. Operands above MAX_N are
// rejected up front. An internal iteration guard catches a compare that never
// deasserts.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   go       in   start request, sampled in IDLE only
//   ack      in   releases DONE or ERR back to IDLE
//   n        in   operand, held stable by the user from go until ack
//   proceed  in   datapath compare: n > (sel_init ? 1 : cnt_q)
//   sel_init out  selects constant 1 into the compare and register path
//   cnt_load out  loads the datapath counter with 1
//   cnt_en   out  increments the datapath counter
//   reg_load out  loads the datapath product register
//   done     out  result valid
//   busy     out  high in INIT and MULT
//   err      out  operand out of range or iteration guard tripped
module fact_ctrl #(
    parameter int unsigned SIZE  = 8,
    parameter int unsigned MAX_N = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            go,
    input  logic            ack,
    input  logic [SIZE-1:0] n,
    input  logic            proceed,
    output logic            sel_init,
    output logic            cnt_load,
    output logic            cnt_en,
    output logic            reg_load,
    output logic            done,
    output logic            busy,
    output logic            err
);

    localparam logic [SIZE-1:0] MAX_N_W = SIZE'(MAX_N);
    localparam logic [SIZE-1:0] ONE_W   = SIZE'(1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        INIT = 3'd1,
        MULT = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [SIZE-1:0] iter_q, iter_d;

    logic sel_init_d, cnt_load_d, cnt_en_d, reg_load_d, done_d, busy_d, err_d;

    // State, iteration guard and Moore outputs. The outputs are registered
    // from the decoded next state, so each one always matches the current state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            iter_q   <= '0;
            sel_init <= 1'b0;
            cnt_load <= 1'b0;
            cnt_en   <= 1'b0;
            reg_load <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state_q  <= state_d;
            iter_q   <= iter_d;
            sel_init <= sel_init_d;
            cnt_load <= cnt_load_d;
            cnt_en   <= cnt_en_d;
            reg_load <= reg_load_d;
            done     <= done_d;
            busy     <= busy_d;
            err      <= err_d;
        end
    end

    // Next-state logic, followed by output decode of that next state.
    always_comb begin
        state_d    = state_q;
        iter_d     = iter_q;
        sel_init_d = 1'b0;
        cnt_load_d = 1'b0;
        cnt_en_d   = 1'b0;
        reg_load_d = 1'b0;
        done_d     = 1'b0;
        busy_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (go) begin
                    state_d = (n > MAX_N_W) ? ERR : INIT;
                end
            end
            INIT: begin
                iter_d  = '0;
                state_d = proceed ? MULT : DONE;
            end
            MULT: begin
                // The guard trips on the MAX_N-th MULT cycle if the compare is still high.
                iter_d = iter_q + ONE_W;
                if (!proceed) begin
                    state_d = DONE;
                end else if (iter_d >= MAX_N_W) begin
                    state_d = ERR;
                end
            end
            DONE: begin
                if (ack) begin
                    state_d = IDLE;
                end
            end
            ERR: begin
                if (ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case (state_d)
            INIT: begin
                sel_init_d = 1'b1;
                cnt_load_d = 1'b1;
                reg_load_d = 1'b1;
                busy_d     = 1'b1;
            end
            MULT: begin
                cnt_en_d   = 1'b1;
                reg_load_d = 1'b1;
                busy_d     = 1'b1;
            end
            DONE:    done_d = 1'b1;
            ERR:     err_d  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fact_ctrl.sv
// tb_fact_ctrl: self-checking bench for fact_ctrl with a behavioural datapath.
// Each start pushes its expected outcome (kind, latency, MULT count, result)
// onto a scoreboard queue. That entry is popped and compared when done or err appears.
module tb_fact_ctrl;

    localparam int unsigned SIZE  = 8;
    localparam int unsigned MAX_N = 5;
    localparam int unsigned LIMIT = 40;

    logic            clk = 1'b0;
    logic            rst, go, ack, proceed;
    logic [SIZE-1:0] n;
    logic            sel_init, cnt_load, cnt_en, reg_load, done, busy, err;

    logic [SIZE-1:0] dp_cnt, dp_reg;
    logic            stuck;

    typedef struct {
        bit          is_err;
        int unsigned result;
        int unsigned lat;
        int unsigned mults;
        bit          dp_act;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned excl_viol = 0;

    fact_ctrl #(.SIZE(SIZE), .MAX_N(MAX_N)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .go       (go),
        .ack      (ack),
        .n        (n),
        .proceed  (proceed),
        .sel_init (sel_init),
        .cnt_load (cnt_load),
        .cnt_en   (cnt_en),
        .reg_load (reg_load),
        .done     (done),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Reference datapath: counter, product register and compare.
    always_comb begin
        proceed = stuck ? 1'b1 : (n > (sel_init ? SIZE'(1) : dp_cnt));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dp_cnt <= '0;
            dp_reg <= '0;
        end else begin
            if (cnt_load)     dp_cnt <= SIZE'(1);
            else if (cnt_en)  dp_cnt <= dp_cnt + SIZE'(1);
            if (reg_load)     dp_reg <= sel_init ? SIZE'(1) : SIZE'(dp_cnt * dp_reg);
        end
    end

    always @(negedge clk) begin
        if ((cnt_load && cnt_en) || (sel_init && cnt_en)) excl_viol++;
    end

    function automatic int unsigned outs();
        return {25'd0, sel_init, cnt_load, cnt_en, reg_load, done, busy, err};
    endfunction

    function automatic int unsigned fact(input int unsigned k);
        int unsigned r = 1;
        for (int unsigned i = 2; i <= k; i++) r = r * i;
        return r % (1 << SIZE);
    endfunction

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Called at a negedge: drives go and pushes the expectation. It returns at the next
    // negedge, which shows the first cycle after go was sampled.
    task automatic start_op(input int unsigned nv, input bit stuck_v);
        exp_t e;
        n     = SIZE'(nv);
        stuck = stuck_v;
        go    = 1'b1;
        if (nv > MAX_N) begin
            e = '{is_err: 1'b1, result: 0, lat: 1, mults: 0, dp_act: 1'b0};
        end else if (stuck_v) begin
            e = '{is_err: 1'b1, result: 0, lat: MAX_N + 2, mults: MAX_N, dp_act: 1'b1};
        end else begin
            e = '{is_err: 1'b0, result: fact(nv), lat: (nv <= 1) ? 2 : nv + 2,
                  mults: (nv <= 1) ? 0 : nv, dp_act: 1'b1};
        end
        sb_q.push_back(e);
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_result(input bit go_in_busy);
        int unsigned k = 1;
        int unsigned mults = 0;
        bit          dp_act = 1'b0;
        bit          hit = 1'b0;
        exp_t        e;
        while (k <= LIMIT) begin
            if (cnt_en) mults++;
            if (reg_load || cnt_load || cnt_en) dp_act = 1'b1;
            if (done || err) begin
                hit = 1'b1;
                break;
            end
            go = (go_in_busy && k == 2);
            @(negedge clk);
            k++;
        end
        go = 1'b0;
        if (!hit) check("timeout", k, 0);
        if (sb_q.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            e = sb_q.pop_front();
            check("kind_err", err, e.is_err);
            check("kind_done", done, !e.is_err);
            check("latency", k, e.lat);
            check("mult_cycles", mults, e.mults);
            check("dp_activity", dp_act, e.dp_act);
            if (!e.is_err) check("result", dp_reg, e.result);
        end
    endtask

    // Holds the terminal state for some cycles, then acks (optionally with go) and confirms IDLE.
    task automatic finish_op(input int unsigned hold, input bit with_go);
        int unsigned term = outs();
        repeat (hold) begin
            @(negedge clk);
            check("term_hold", outs(), term);
        end
        ack = 1'b1;
        go  = with_go;
        @(negedge clk);
        ack = 1'b0;
        go  = 1'b0;
        check("idle_after_ack", outs(), 0);
        @(negedge clk);
        check("idle_stays", outs(), 0);
    endtask

    initial begin
        rst = 1'b1; go = 1'b0; ack = 1'b0; n = '0; stuck = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outs", outs(), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_outs", outs(), 0);

        // Normal n=5, including go pulsed while busy.
        start_op(5, 1'b0);
        check("init_outs", outs(), 7'b1101010);
        wait_result(1'b1);
        finish_op(3, 1'b0);

        // Small and mid-range operands.
        for (int unsigned v = 0; v <= 3; v++) begin
            start_op(v, 1'b0);
            wait_result(1'b0);
            finish_op(1, 1'b0);
        end

        // Out-of-range operands.
        start_op(6, 1'b0);
        wait_result(1'b0);
        finish_op(2, 1'b0);
        start_op(255, 1'b0);
        wait_result(1'b0);
        finish_op(1, 1'b0);

        // Reset during the second MULT cycle of n=4, followed by n=3.
        start_op(4, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("mid_mult_busy", outs(), 7'b0011010);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_outs", outs(), 0);
        void'(sb_q.pop_front());
        repeat (3) begin
            @(negedge clk);
            check("no_partial_done", outs(), 0);
        end
        start_op(3, 1'b0);
        wait_result(1'b0);
        finish_op(1, 1'b0);

        // Stuck compare trips the iteration guard.
        start_op(3, 1'b1);
        wait_result(1'b0);
        stuck = 1'b0;
        finish_op(1, 1'b0);

        // go together with ack in DONE returns to IDLE only.
        start_op(2, 1'b0);
        wait_result(1'b0);
        finish_op(1, 1'b1);

        // MAX_N operand still completes normally.
        start_op(MAX_N, 1'b0);
        wait_result(1'b0);
        finish_op(1, 1'b0);

        check("exclusive_ctrl", excl_viol, 0);
        check("sb_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
